// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if: time, button and player-control signals between the clock logic and alarm_sequencer.
interface alarm_sequencer_if;
  logic       tick_1hz;
  logic       alarm_set;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic [4:0] alm_hr;
  logic [5:0] alm_min;
  logic       snooze_btn;
  logic       stop_btn;
  logic       player_en;
  logic       player_stop;
  logic       snoozing;
  logic [2:0] snooze_cnt;
  modport master (
    output tick_1hz, alarm_set, cur_hr, cur_min, alm_hr, alm_min, snooze_btn, stop_btn,
    input  player_en, player_stop, snoozing, snooze_cnt
  );
  modport slave (
    input  tick_1hz, alarm_set, cur_hr, cur_min, alm_hr, alm_min, snooze_btn, stop_btn,
    output player_en, player_stop, snoozing, snooze_cnt
  );
endinterface

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: ring/snooze/hold FSM driving alarm_player from the 1 Hz tick and alarm-time match.
module alarm_sequencer #(
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int SNOOZE_SEC       = 300,
  parameter int MAX_SNOOZE       = 3
) (
  input logic             clk,
  input logic             rst,
  alarm_sequencer_if.slave bus
);
  localparam int MAXT = (RING_TIMEOUT_SEC > SNOOZE_SEC) ? RING_TIMEOUT_SEC : SNOOZE_SEC;
  localparam int W    = $clog2(MAXT + 1);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE, HOLD} state_e;
  state_e       state_q, state_d;
  logic [W-1:0] sec_q, sec_d;
  logic [2:0]   snz_q, snz_d;
  logic         match, can_snooze, ring_done, snooze_done;
  assign match       = bus.alarm_set && bus.cur_hr == bus.alm_hr && bus.cur_min == bus.alm_min;
  assign can_snooze  = snz_q < 3'(MAX_SNOOZE);
  assign ring_done   = bus.tick_1hz && sec_q == W'(RING_TIMEOUT_SEC - 1);
  assign snooze_done = bus.tick_1hz && sec_q == W'(SNOOZE_SEC - 1);
  always_comb begin
    state_d = state_q;
    snz_d   = snz_q;
    if (!bus.alarm_set) begin
      state_d = IDLE;
      snz_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (match) state_d = RING;
        RING:
          if (bus.stop_btn) state_d = HOLD;
          else if (bus.snooze_btn) begin
            if (can_snooze) begin
              state_d = SNOOZE;
              snz_d   = snz_q + 3'd1;
            end
          end else if (ring_done) begin
            state_d = can_snooze ? SNOOZE : HOLD;
            snz_d   = can_snooze ? snz_q + 3'd1 : snz_q;
          end
        SNOOZE:
          if (bus.stop_btn) state_d = HOLD;
          else if (snooze_done) state_d = RING;
        default:
          if (!match) begin
            state_d = IDLE;
            snz_d   = '0;
          end
      endcase
    end
    // A tick on the entry edge is dropped so each phase lasts exactly its tick count
    sec_d = (state_d != state_q) ? '0 : (bus.tick_1hz && sec_q != '1) ? sec_q + W'(1) : sec_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sec_q   <= '0;
      snz_q   <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      snz_q   <= snz_d;
    end
  end
  assign bus.player_en   = state_q == RING;
  assign bus.player_stop = state_q != RING;
  assign bus.snoozing    = state_q == SNOOZE;
  assign bus.snooze_cnt  = snz_q;
endmodule
